// File: rtl/face_pkg.sv
// Purpose : shared types and face bitmaps for the end-of-game matrix display.
// Latency : n/a (constants, types and a pure lookup function only).
// Backpr. : n/a (no flow control; consumers index the tables combinationally).
package face_pkg;

    localparam int FACE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHOW_WIN,
        SHOW_LOSE,
        DONE
    } state_t;

    typedef enum logic {
        SEL_SMILE,
        SEL_FROWN
    } face_sel_t;

    // Index = row, bit 0 = leftmost column.
    localparam logic [FACE_W-1:0] FACE_SMILE [FACE_W] = '{
        8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h42, 8'h24, 8'h18
    };

    localparam logic [FACE_W-1:0] FACE_FROWN [FACE_W] = '{
        8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h18, 8'h24, 8'h42
    };

    function automatic logic [FACE_W-1:0] face_row(face_sel_t sel, logic [2:0] row);
        return (sel == SEL_FROWN) ? FACE_FROWN[row] : FACE_SMILE[row];
    endfunction

endpackage

// File: rtl/face_matrix_display_if.sv
// Purpose : bundles game-FSM triggers and matrix/buzzer outputs of the face display.
// Latency : n/a (wires only).
// Backpr. : none; triggers are level/pulse inputs, outputs are free-running.
// Ports   : success/fail (game -> display), hang/gre/beep/repeat_rst/busy (display -> board).
interface face_matrix_display_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic            success;
    logic            fail;
    logic [ROWS-1:0] hang;
    logic [COLS-1:0] gre;
    logic            beep;
    logic            repeat_rst;
    logic            busy;

    // Game-control side.
    modport master (
        output success, fail,
        input  hang, gre, beep, repeat_rst, busy
    );

    // Display side.
    modport slave (
        input  success, fail,
        output hang, gre, beep, repeat_rst, busy
    );
endinterface

// File: rtl/face_rom.sv
// Purpose : combinational face bitmap lookup, zero-padded past the 8x8 art.
// Latency : 0 cycles (pure combinational).
// Backpr. : none.
// Ports   : face_sel, row_idx in; row_dat (COLS bits, bit 0 = leftmost column) out.
module face_rom
    import face_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    localparam int RW  = $clog2(ROWS)
) (
    input  face_sel_t         face_sel,
    input  logic [RW-1:0]     row_idx,
    output logic [COLS-1:0]   row_dat
);

    always_comb begin
        row_dat = '0;
        // Extra bit on the compare so RW=3 does not truncate FACE_W to zero.
        if ({1'b0, row_idx} < (RW+1)'(FACE_W)) begin
            row_dat[FACE_W-1:0] = face_row(face_sel, row_idx[2:0]);
        end
    end

endmodule

// File: rtl/face_matrix_display.sv
// Purpose : scans a smile/frown face on the LED matrix, beeps, then requests a restart.
// Latency : outputs registered; first face row appears the cycle after the trigger is sampled.
// Backpr. : none; triggers ignored outside IDLE, DONE holds until rst_n.
// Ports   : clk, rst_n (sync, active-low), bus (slave: success/fail in; hang/gre/beep/repeat_rst/busy out).
module face_matrix_display
    import face_pkg::*;
#(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int SCAN_DIV    = 1,
    parameter int BEEP_HALF   = 11,
    parameter int LOSE_MULT   = 4,
    parameter int HOLD_CYCLES = 501
) (
    input  logic                 clk,
    input  logic                 rst_n,
    face_matrix_display_if.slave bus
);

    localparam int RW      = $clog2(ROWS);
    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BEEP_W  = (BEEP_HALF * LOSE_MULT > 1) ? $clog2(BEEP_HALF * LOSE_MULT) : 1;
    localparam int HOLD_W  = $clog2(HOLD_CYCLES);

    state_t              state_q, state_d;
    face_sel_t           face_q, face_d;
    logic [RW-1:0]       row_q, row_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                beep_q, beep_d;
    logic                repeat_q, repeat_d;
    logic                busy_d;
    logic [ROWS-1:0]     hang_q, hang_d;
    logic [COLS-1:0]     gre_q, gre_d;
    logic [COLS-1:0]     rom_dat;
    logic [BEEP_W-1:0]   beep_term;

    // ROM is addressed with next-state face/row so gre lines up with hang after the register.
    face_rom #(.ROWS(ROWS), .COLS(COLS)) u_rom (
        .face_sel (face_d),
        .row_idx  (row_d),
        .row_dat  (rom_dat)
    );

    assign beep_term = (state_q == SHOW_WIN) ? BEEP_W'(BEEP_HALF - 1)
                                             : BEEP_W'(BEEP_HALF * LOSE_MULT - 1);

    always_comb begin
        state_d    = state_q;
        face_d     = face_q;
        row_d      = row_q;
        div_d      = div_q;
        beep_cnt_d = beep_cnt_q;
        hold_d     = hold_q;
        beep_d     = beep_q;
        repeat_d   = repeat_q;

        // Row scan keeps running in DONE so the face stays visible.
        if (state_q != IDLE) begin
            if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                div_d = '0;
                row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                row_d      = '0;
                div_d      = '0;
                beep_cnt_d = '0;
                hold_d     = '0;
                beep_d     = 1'b0;
                repeat_d   = 1'b0;
                if (bus.success) begin
                    state_d = SHOW_WIN;
                    face_d  = SEL_SMILE;
                end else if (bus.fail) begin
                    state_d = SHOW_LOSE;
                    face_d  = SEL_FROWN;
                end
            end
            SHOW_WIN, SHOW_LOSE: begin
                if (beep_cnt_q == beep_term) begin
                    beep_cnt_d = '0;
                    beep_d     = ~beep_q;
                end else begin
                    beep_cnt_d = beep_cnt_q + 1'b1;
                end
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d  = DONE;
                    beep_d   = 1'b0;
                    repeat_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            DONE: begin
                beep_d   = 1'b0;
                repeat_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        hang_d = busy_d ? ~(ROWS'(1) << row_d) : '1;
        gre_d  = busy_d ? rom_dat : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            face_q     <= SEL_SMILE;
            row_q      <= '0;
            div_q      <= '0;
            beep_cnt_q <= '0;
            hold_q     <= '0;
            beep_q     <= 1'b0;
            repeat_q   <= 1'b0;
            hang_q     <= '1;
            gre_q      <= '0;
            bus.busy   <= 1'b0;
        end else begin
            state_q    <= state_d;
            face_q     <= face_d;
            row_q      <= row_d;
            div_q      <= div_d;
            beep_cnt_q <= beep_cnt_d;
            hold_q     <= hold_d;
            beep_q     <= beep_d;
            repeat_q   <= repeat_d;
            hang_q     <= hang_d;
            gre_q      <= gre_d;
            bus.busy   <= busy_d;
        end
    end

    assign bus.hang       = hang_q;
    assign bus.gre        = gre_q;
    assign bus.beep       = beep_q;
    assign bus.repeat_rst = repeat_q;

endmodule

// File: tb/tb_face_matrix_display.sv
// Purpose : directed self-checking bench for face_matrix_display.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_face_matrix_display;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    face_matrix_display_if #(.ROWS(8), .COLS(8)) bus ();

    face_matrix_display #(
        .ROWS(8), .COLS(8), .SCAN_DIV(1), .BEEP_HALF(3), .LOSE_MULT(2), .HOLD_CYCLES(20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [7:0] smile_tab [8] = '{8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h42, 8'h24, 8'h18};
    logic [7:0] frown_tab [8] = '{8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h18, 8'h24, 8'h42};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.success = 1'b0;
        bus.fail    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp += 5;
            if (bus.hang !== 8'hFF) begin n_bad++; $display("FAIL reset_hang c=%0d got %h want ff", c, bus.hang); end
            if (bus.gre !== 8'h00) begin n_bad++; $display("FAIL reset_gre c=%0d got %h want 00", c, bus.gre); end
            if (bus.beep !== 1'b0) begin n_bad++; $display("FAIL reset_beep c=%0d got %b want 0", c, bus.beep); end
            if (bus.repeat_rst !== 1'b0) begin n_bad++; $display("FAIL reset_repeat c=%0d got %b want 0", c, bus.repeat_rst); end
            if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy c=%0d got %b want 0", c, bus.busy); end
        end
    endtask

    // e = cycles since the first scanned row (e=0 is that row).
    task automatic test_win();
        logic [7:0] exp_hang;
        logic       exp_beep;
        do_reset();
        @(negedge clk); bus.success = 1'b1;
        @(negedge clk); bus.success = 1'b0;
        for (int e = 0; e < 30; e++) begin
            if (e > 0) @(negedge clk);
            exp_hang = ~(8'h01 << (e % 8));
            exp_beep = (e < 20) && (((e / 3) % 2) == 1);
            n_cmp += 5;
            if (bus.hang !== exp_hang) begin n_bad++; $display("FAIL win_hang e=%0d got %h want %h", e, bus.hang, exp_hang); end
            if (bus.gre !== smile_tab[e % 8]) begin n_bad++; $display("FAIL win_gre e=%0d got %h want %h", e, bus.gre, smile_tab[e % 8]); end
            if (bus.beep !== exp_beep) begin n_bad++; $display("FAIL win_beep e=%0d got %b want %b", e, bus.beep, exp_beep); end
            if (bus.repeat_rst !== (e >= 20)) begin n_bad++; $display("FAIL win_repeat e=%0d got %b want %b", e, bus.repeat_rst, (e >= 20)); end
            if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL win_busy e=%0d got %b want 1", e, bus.busy); end
        end
    endtask

    // Lose run with success raised mid-show; it must not change face or cadence.
    task automatic test_lose();
        logic [7:0] exp_hang;
        logic       exp_beep;
        do_reset();
        @(negedge clk); bus.fail = 1'b1;
        @(negedge clk); bus.fail = 1'b0;
        for (int e = 0; e < 30; e++) begin
            if (e > 0) @(negedge clk);
            exp_hang = ~(8'h01 << (e % 8));
            exp_beep = (e < 20) && (((e / 6) % 2) == 1);
            n_cmp += 5;
            if (bus.hang !== exp_hang) begin n_bad++; $display("FAIL lose_hang e=%0d got %h want %h", e, bus.hang, exp_hang); end
            if (bus.gre !== frown_tab[e % 8]) begin n_bad++; $display("FAIL lose_gre e=%0d got %h want %h", e, bus.gre, frown_tab[e % 8]); end
            if (bus.beep !== exp_beep) begin n_bad++; $display("FAIL lose_beep e=%0d got %b want %b", e, bus.beep, exp_beep); end
            if (bus.repeat_rst !== (e >= 20)) begin n_bad++; $display("FAIL lose_repeat e=%0d got %b want %b", e, bus.repeat_rst, (e >= 20)); end
            if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL lose_busy e=%0d got %b want 1", e, bus.busy); end
            bus.success = (e >= 4 && e < 9);
        end
        bus.success = 1'b0;
    endtask

    task automatic test_both();
        logic       exp_beep;
        do_reset();
        @(negedge clk); bus.success = 1'b1; bus.fail = 1'b1;
        @(negedge clk); bus.success = 1'b0; bus.fail = 1'b0;
        for (int e = 0; e < 16; e++) begin
            if (e > 0) @(negedge clk);
            exp_beep = (((e / 3) % 2) == 1);
            n_cmp += 2;
            if (bus.gre !== smile_tab[e % 8]) begin n_bad++; $display("FAIL both_gre e=%0d got %h want %h", e, bus.gre, smile_tab[e % 8]); end
            if (bus.beep !== exp_beep) begin n_bad++; $display("FAIL both_beep e=%0d got %b want %b", e, bus.beep, exp_beep); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_hang;
        do_reset();
        @(negedge clk); bus.success = 1'b1;
        @(negedge clk); bus.success = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp += 5;
        if (bus.hang !== 8'hFF) begin n_bad++; $display("FAIL mid_rst_hang got %h want ff", bus.hang); end
        if (bus.gre !== 8'h00) begin n_bad++; $display("FAIL mid_rst_gre got %h want 00", bus.gre); end
        if (bus.beep !== 1'b0) begin n_bad++; $display("FAIL mid_rst_beep got %b want 0", bus.beep); end
        if (bus.repeat_rst !== 1'b0) begin n_bad++; $display("FAIL mid_rst_repeat got %b want 0", bus.repeat_rst); end
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", bus.busy); end
        rst_n = 1'b1;
        @(negedge clk); bus.fail = 1'b1;
        @(negedge clk); bus.fail = 1'b0;
        for (int e = 0; e < 23; e++) begin
            if (e > 0) @(negedge clk);
            exp_hang = ~(8'h01 << (e % 8));
            n_cmp += 3;
            if (bus.hang !== exp_hang) begin n_bad++; $display("FAIL restart_hang e=%0d got %h want %h", e, bus.hang, exp_hang); end
            if (bus.gre !== frown_tab[e % 8]) begin n_bad++; $display("FAIL restart_gre e=%0d got %h want %h", e, bus.gre, frown_tab[e % 8]); end
            if (bus.repeat_rst !== (e >= 20)) begin n_bad++; $display("FAIL restart_repeat e=%0d got %b want %b", e, bus.repeat_rst, (e >= 20)); end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.success = 1'b0;
        bus.fail    = 1'b0;
        test_reset();
        test_win();
        test_lose();
        test_both();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
